// File: rtl/fp_convert_unit.sv
// rtl/fp_convert_unit.sv - iterative int<->IEEE-754 single converter with start/busy/done handshake
module fp_convert_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dir,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        invalid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PACK  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_dir;
  logic        r_sign;
  logic [31:0] r_mag;
  logic [4:0]  r_cnt;
  logic        r_special;
  logic [31:0] r_spec_res;
  logic        r_spec_inv;
  logic [31:0] r_result;
  logic        r_invalid;
  logic        r_done;

  logic [7:0]  w_exp;
  logic [22:0] w_frac;
  logic [31:0] w_abs;
  logic [4:0]  w_f2i_cnt;
  logic        w_cap_special;
  logic [31:0] w_cap_res;
  logic        w_cap_inv;
  logic        w_shift_done;
  logic [7:0]  w_i2f_exp;
  logic [31:0] w_pack_result;
  logic        w_pack_invalid;

  assign w_exp     = operand[30:23];
  assign w_frac    = operand[22:0];
  // 0x80000000 negates to itself, which is exactly the magnitude wanted
  assign w_abs     = operand[31] ? (~operand + 32'd1) : operand;
  assign w_f2i_cnt = 5'(8'd158 - w_exp);

  // Float inputs that never need the shifter: NaN/Inf, |x|<1, and |x|>=2^31
  always_comb begin
    w_cap_special = 1'b0;
    w_cap_res     = 32'h0000_0000;
    w_cap_inv     = 1'b0;
    if (w_exp == 8'hFF) begin
      w_cap_special = 1'b1;
      w_cap_res     = 32'h7FFF_FFFF;
      w_cap_inv     = 1'b1;
    end else if (w_exp < 8'd127) begin
      w_cap_special = 1'b1;
    end else if (w_exp >= 8'd158) begin
      w_cap_special = 1'b1;
      if (operand[31] && (w_exp == 8'd158) && (w_frac == 23'd0)) begin
        w_cap_res = 32'h8000_0000;
      end else begin
        w_cap_res = operand[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        w_cap_inv = 1'b1;
      end
    end
  end

  assign w_shift_done = r_dir ? (r_cnt == 5'd0) : (r_mag[31] | (r_mag == 32'd0));
  assign w_i2f_exp    = 8'd158 - {3'b000, r_cnt};

  always_comb begin
    w_pack_result  = 32'h0000_0000;
    w_pack_invalid = 1'b0;
    if (r_dir) begin
      if (r_special) begin
        w_pack_result  = r_spec_res;
        w_pack_invalid = r_spec_inv;
      end else begin
        w_pack_result = r_sign ? (~r_mag + 32'd1) : r_mag;
      end
    end else if (r_mag != 32'd0) begin
      w_pack_result = {r_sign, w_i2f_exp, r_mag[30:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_SHIFT;
      S_SHIFT: if (w_shift_done) w_next_state = S_PACK;
      S_PACK:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_SHIFT) || (r_state == S_PACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir      <= 1'b0;
      r_sign     <= 1'b0;
      r_mag      <= 32'd0;
      r_cnt      <= 5'd0;
      r_special  <= 1'b0;
      r_spec_res <= 32'd0;
      r_spec_inv <= 1'b0;
      r_result   <= 32'd0;
      r_invalid  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dir  <= dir;
            r_sign <= operand[31];
            if (!dir) begin
              r_mag      <= w_abs;
              r_cnt      <= 5'd0;
              r_special  <= 1'b0;
              r_spec_res <= 32'd0;
              r_spec_inv <= 1'b0;
            end else begin
              r_mag      <= {1'b1, w_frac, 8'h00};
              r_cnt      <= w_cap_special ? 5'd0 : w_f2i_cnt;
              r_special  <= w_cap_special;
              r_spec_res <= w_cap_res;
              r_spec_inv <= w_cap_inv;
            end
          end
        end
        S_SHIFT: begin
          if (!w_shift_done) begin
            if (r_dir) begin
              r_mag <= r_mag >> 1;
              r_cnt <= r_cnt - 5'd1;
            end else begin
              r_mag <= r_mag << 1;
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        S_PACK: begin
          r_result  <= w_pack_result;
          r_invalid <= w_pack_invalid;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done    = r_done;
  assign result  = r_result;
  assign invalid = r_invalid;

endmodule

// File: doc/fp_convert_unit.md
# fp_convert_unit

Multi-cycle IEEE-754 single-precision converter for the Mini-MIPS execute stage: int→float (cvt.s.w) and float→int (cvt.w.s).

- It produces the FP encodings that the ALU's floating-point add, subtract and compare operations consume.
- It also decodes those encodings back to two's-complement integers.
- Normalization and denormalization are done iteratively, one bit per cycle, so no barrel shifter is needed.
- A start/busy/done handshake stalls the pipeline while a conversion runs.

## Interface
Parameters: none.

- `clk`  in  1  clock. One clock domain only; all state changes on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `start`  in  1  request a conversion. Sampled only in IDLE.
- `dir`  in  1  conversion direction: 0 = int→float, 1 = float→int. Sampled with `start`.
- `operand`  in  32  source value: signed integer when `dir`=0, IEEE-754 single when `dir`=1.
- `busy`  out  1  high while in SHIFT or PACK.
- `done`  out  1  one-cycle pulse; `result` and `invalid` are valid in that cycle.
- `result`  out  32  converted value. Held until the next `done`.
- `invalid`  out  1  float→int was NaN, Inf or out of range. Held with `result`.

## Operation

**States:** IDLE → SHIFT → PACK → IDLE.

**IDLE**
- `start`=1 captures `dir`, sign and a 32-bit magnitude register `mag`, then moves to SHIFT.
- `start` in SHIFT or PACK is ignored.

**int→float (`dir`=0) capture**
- `mag` = |operand|, as unsigned 32 bits. 0x80000000 gives `mag`=0x80000000.
- Shift counter = 0.

**int→float SHIFT**
- If `mag`[31]=1 or `mag`=0: go to PACK.
- Otherwise: `mag` <<= 1, counter++.

**int→float PACK**
- `mag`=0: result = 0x00000000.
- Otherwise: result = {sign, 8'(158−counter), `mag`[30:8]}.
- Rounding is truncation toward zero. Dropped bits `mag`[7:0] are discarded.
- `invalid` = 0.

**float→int (`dir`=1) capture.** Let e = operand[30:23] and s = operand[31].
- e=255 (NaN or Inf): special. Result = 0x7FFFFFFF, `invalid`=1.
- e<127 (includes zeros and denormals): special. Result = 0, `invalid`=0.
- e≥158:
  - If s=1, e=158 and frac=0: result = 0x80000000, `invalid`=0.
  - Else: result = 0x7FFFFFFF if s=0, 0x80000000 if s=1; `invalid`=1.
- Otherwise (normal): `mag` = {1, frac, 8'b0}, counter = 158−e (range 1..31).
- Special cases load counter = 0 and carry their preset result through.

**float→int SHIFT**
- Counter=0: go to PACK.
- Otherwise: `mag` >>= 1 (logical), counter−−.

**float→int PACK**
- Normal case: result = s ? −`mag` : `mag`. Truncates toward zero.

**PACK → IDLE edge:** registers `result` and `invalid`, and sets `done`=1 for exactly one cycle.

**Arithmetic:** all arithmetic is 32-bit unsigned on `mag`. The exponent is computed in 8 bits; 158−counter always lies in 127..158.

## Timing

**Reset values:** state=IDLE, `busy`=0, `done`=0, `result`=0, `invalid`=0.

**Latency.** Let k be the number of SHIFT iterations that move `mag`:
- int→float: k = leading-zero count of the magnitude (0..31). k=0 for 0 and for 0x80000000.
- float→int: k = 158−e for normal inputs, 0 for special cases.
- `start` is sampled at edge 0 and `done` is high in the cycle after edge k+2.
- Latency is therefore k+2 cycles: minimum 2, maximum 33.

**Handshake timing**
- `busy` rises the cycle after `start` is accepted.
- `busy` falls in the same cycle `done` is high.
- A new `start` in the `done` cycle is accepted (back-to-back, no bubble).

**Reset during an operation**
- Aborts the conversion; no `done` is produced.
- `result` clears to 0 and `busy`=0 in the next cycle.

**Simultaneous `rst` and `start`:** reset wins and the start is dropped.

## Test plan
- Reset, then int→float. The `done` pulse must be exactly one cycle wide in every case.
  - 0x00000001 → 0x3F800000, latency 33.
  - 0xFFFFFFFB (−5) → 0xC0A00000, latency 31.
  - 0x00000000 → 0x00000000, latency 2.
  - 0x80000000 → 0xCF000000, latency 2.
- int→float truncation: 0x01000001 → 0x4B800000, latency 9.
- float→int normals:
  - 0x40490FDB (3.14159) → 0x00000003, latency 32.
  - 0xC0200000 (−2.5) → 0xFFFFFFFE, latency 32.
  - 0x3F000000 (0.5) → 0x00000000, latency 2.
- float→int specials, all latency 2:
  - 0x7F800000 → 0x7FFFFFFF, `invalid`=1.
  - 0x4F000000 → 0x7FFFFFFF, `invalid`=1.
  - 0xCF000000 → 0x80000000, `invalid`=0.
  - 0x7FC00000 → 0x7FFFFFFF, `invalid`=1.
- Handshake:
  - `start` pulsed 3 cycles into a 33-cycle conversion → ignored, and the original result is unchanged.
  - `start` in the `done` cycle → second conversion accepted immediately.
- `rst` 5 cycles into int→float of 0x00000001 → no `done`, and `busy`=0, `result`=0 the next cycle.
